// File: rtl/sha256_digest_serializer.sv
// Serializes 256-bit SHA-256 digests onto an 8-bit valid/ready stream,
// either as 32 raw bytes or as 64 lowercase ASCII hex characters, with a
// one-deep pending buffer for a digest that arrives while one is in flight.
module sha256_digest_serializer #(
    parameter int unsigned HEX_ASCII = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] hash_in,
    input  logic         hash_valid,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         tx_last,
    output logic         busy,
    output logic         overrun
);

    localparam int unsigned DIGEST_W = 256;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned CNT_W    = (HEX_ASCII != 0) ? 6 : 5;
    localparam int unsigned LAST_IDX = (HEX_ASCII != 0) ? 63 : 31;
    localparam logic [CNT_W-1:0] LAST_ITEM = CNT_W'(LAST_IDX);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                state_q, state_nxt;
    logic [DIGEST_W-1:0]   active_q, active_nxt;
    logic [DIGEST_W-1:0]   pend_q, pend_nxt;
    logic                  pend_valid_q, pend_valid_nxt;
    logic [CNT_W-1:0]      cnt_q, cnt_nxt;
    logic                  overrun_nxt;
    logic [BYTE_W-1:0]     tx_data_nxt;
    logic                  tx_valid_nxt;
    logic                  tx_last_nxt;
    logic                  busy_nxt;
    logic                  xfer_c;
    logic                  final_xfer_c;

    // Item presented for a given top byte: the byte itself, or one hex char of it.
    function automatic logic [BYTE_W-1:0] item_char(input logic [BYTE_W-1:0] top,
                                                    input logic              low_nib);
        logic [3:0]        nib;
        logic [BYTE_W-1:0] hex_char;
        nib      = low_nib ? top[3:0] : top[7:4];
        hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
        return (HEX_ASCII != 0) ? hex_char : top;
    endfunction

    // A transfer happens whenever the sink is ready while a digest is being sent.
    assign xfer_c       = (state_q == SEND) && tx_ready;
    assign final_xfer_c = xfer_c && (cnt_q == LAST_ITEM);

    // Registers: FSM state, shift register, pending slot and the registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            active_q     <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            cnt_q        <= '0;
            overrun      <= 1'b0;
            tx_data      <= '0;
            tx_valid     <= 1'b0;
            tx_last      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            active_q     <= active_nxt;
            pend_q       <= pend_nxt;
            pend_valid_q <= pend_valid_nxt;
            cnt_q        <= cnt_nxt;
            overrun      <= overrun_nxt;
            tx_data      <= tx_data_nxt;
            tx_valid     <= tx_valid_nxt;
            tx_last      <= tx_last_nxt;
            busy         <= busy_nxt;
        end
    end

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_nxt      = state_q;
        active_nxt     = active_q;
        pend_nxt       = pend_q;
        pend_valid_nxt = pend_valid_q;
        cnt_nxt        = cnt_q;
        overrun_nxt    = overrun;

        case (state_q)
            IDLE: begin
                if (hash_valid) begin
                    active_nxt = hash_in;
                    cnt_nxt    = '0;
                    state_nxt  = SEND;
                end
            end
            SEND: begin
                if (xfer_c) begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                    // Hex mode keeps the byte in place until its low-nibble char goes out.
                    if ((HEX_ASCII == 0) || cnt_q[0]) begin
                        active_nxt = {active_q[DIGEST_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
                    end
                end
                if (final_xfer_c) begin
                    cnt_nxt = '0;
                    if (pend_valid_q) begin
                        active_nxt = pend_q;
                        if (hash_valid) begin
                            pend_nxt = hash_in;
                        end else begin
                            pend_valid_nxt = 1'b0;
                        end
                    end else if (hash_valid) begin
                        active_nxt = hash_in;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (hash_valid) begin
                    if (!pend_valid_q) begin
                        pend_nxt       = hash_in;
                        pend_valid_nxt = 1'b1;
                    end else begin
                        overrun_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        tx_valid_nxt = (state_nxt == SEND);
        tx_data_nxt  = tx_valid_nxt ? item_char(active_nxt[DIGEST_W-1 -: BYTE_W], cnt_nxt[0])
                                    : {BYTE_W{1'b0}};
        tx_last_nxt  = tx_valid_nxt && (cnt_nxt == LAST_ITEM);
        busy_nxt     = tx_valid_nxt || pend_valid_nxt;
    end

endmodule

// File: doc/sha256_digest_serializer.md
SHA256_DIGEST_SERIALIZER -- requirements
Module: sha256_digest_serializer

Interface
REQ-001 SHALL have parameter HEX_ASCII, default 0; 0 = 32 raw digest bytes per hash, 1 = 64 lowercase ASCII hex characters per hash.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port hash_in  input  256  digest from the hash core; bits [255:248] are the first digest byte.
REQ-005 SHALL have port hash_valid  input  1  one-cycle pulse; hash_in valid in that cycle; no backpressure is possible.
REQ-006 SHALL have port tx_data  output  8  outgoing byte.
REQ-007 SHALL have port tx_valid  output  1  tx_data, tx_last are valid.
REQ-008 SHALL have port tx_ready  input  1  sink accepts; a transfer occurs when tx_valid && tx_ready.
REQ-009 SHALL have port tx_last  output  1  high on the final byte of a digest (byte 31, or char 63 if HEX_ASCII=1).
REQ-010 SHALL have port busy  output  1  high while a digest is being sent or one is pending.
REQ-011 SHALL have port overrun  output  1  sticky; a digest was dropped.

Function
REQ-012 SHALL have two states: IDLE (tx_valid=0) and SEND (tx_valid=1).
REQ-013 SHALL hold an active shift register (256 bits), a one-deep pending buffer (256 bits plus a valid flag), and an item counter (5 bits raw, 6 bits hex).
REQ-014 In IDLE, on hash_valid, SHALL load hash_in into active, clear the counter, and enter SEND; tx_valid SHALL be 1 on the next cycle (latency 1).
REQ-015 SHALL output digest bytes MSB-first: byte k = hash_in[255-8k -: 8].
REQ-016 With HEX_ASCII=1, SHALL send each byte high nibble first. Nibble 0-9 maps to 0x30-0x39 and a-f maps to 0x61-0x66.
REQ-017 While tx_valid=1 and tx_ready=0, tx_data, tx_last and tx_valid SHALL stay stable.
REQ-018 On each transfer, SHALL advance exactly one item: the counter increments; the active register shifts left 8 bits (raw), or 8 bits after the low-nibble char (hex).
REQ-019 tx_last SHALL be 1 only when the counter equals 31 (raw) or 63 (hex).
REQ-020 On a transfer with tx_last=1, SHALL load the pending buffer into active and stay in SEND if pending is valid, with no idle cycle on tx_valid. Otherwise it SHALL return to IDLE.
REQ-021 If hash_valid arrives in SEND with pending empty, SHALL store hash_in in pending.
REQ-022 If hash_valid arrives in SEND with pending full and no final transfer that cycle, SHALL drop hash_in, keep pending unchanged, and set overrun.
REQ-023 If hash_valid coincides with a final transfer:
  - pending full: pending moves to active and hash_in goes to pending; no overrun.
  - pending empty: hash_in loads directly into active and SEND continues.
REQ-024 overrun SHALL clear only on reset.
REQ-025 busy SHALL equal (state==SEND) || pending valid.
REQ-026 Counters SHALL never wrap mid-digest; the counter SHALL clear on every load of active.

Reset
REQ-027 Asserting reset (0) at any time, including mid-digest, SHALL immediately force:
  - state IDLE, counter 0, pending invalid;
  - tx_valid=0, tx_last=0, tx_data=0x00, busy=0, overrun=0.
  Any partially sent digest is discarded.
REQ-028 After release, the first rising edge with hash_valid=1 SHALL start a new digest per REQ-014.

Verification
REQ-029 Raw mode, tx_ready=1, hash_in=ba7816bf...f20015ad ("abc" digest), one pulse -> 32 consecutive transfers starting the cycle after the pulse: 0xba, 0x78, 0x16, 0xbf, ... 0xad; tx_last only on 0xad; then IDLE, busy=0.
REQ-030 Hex mode, same digest -> 64 transfers: 0x62('b'), 0x61('a'), 0x37, 0x38, ... 0x61, 0x64; tx_last on the 64th.
REQ-031 Raw mode, tx_ready toggling 1,0,0,1 -> tx_data held while tx_ready=0; exactly 32 transfers, no byte duplicated or skipped.
REQ-032 Digests A, B, C pulsed at cycles 0, 3, 6 with tx_ready=1:
  - A and B are sent back-to-back with no tx_valid gap;
  - C is dropped and overrun=1 from cycle 7 onward.
REQ-033 A pulse of digest D coincides with A's final transfer while B is pending -> the sequence sent is A, B, D; overrun stays 0.
REQ-034 reset asserted after byte 10 of a digest -> tx_valid=0 and busy=0 immediately; after release and a new pulse, byte 0 of the new digest is sent first.
